adder_share_arbiter: RTL

Shares a single `ripple_carry_adder_60bit` datapath among NREQ requesters. It arbitrates round-robin, latches the winner's operands, and lets the combinational carry chain settle for one full cycle. It then returns the (WIDTH+1)-bit sum tagged with the requester index through a valid/ready response port. It sits between client blocks that need occasional wide additions and the one adder instance the team budgets for area.

---
 rtl/adder_share_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: one ripple-carry adder shared by NREQ requesters.
// Grant in IDLE, one full cycle for the carry chain to settle in ADD, then
// the {carry, sum} result is held in RESP until the consumer takes it.
// Optional build macro: ADDER_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.

// One bit cell of the carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// Purely combinational ripple-carry adder built from an array of bit cells.
module ripple_carry_adder_60bit #(
    parameter int WIDTH = 60
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];
endmodule

module adder_share_arbiter #(
    parameter int  WIDTH = 60,
    parameter int  NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_rsp_valid,
    output logic [IDW-1:0]        o_rsp_id,
    output logic [WIDTH:0]        o_rsp_result,
    input  logic                  i_rsp_ready,
    output logic                  o_busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic [NREQ-1:0]   ready_vec;
    logic              handshake;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [IDW-1:0]    id_q;
    logic [WIDTH-1:0]  add_sum;
    logic              add_cout;
    logic [WIDTH:0]    result_q;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    // Fixed priority: scan from the top down so the lowest valid index wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] last_q;

    // Round-robin: first look above the last winner, then wrap to 0..last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && i_req_valid[k] && (k > int'(last_q))) begin
                grant_any = 1'b1;
                grant_idx = IDW'(k);
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && i_req_valid[k] && (k <= int'(last_q))) begin
                grant_any = 1'b1;
                grant_idx = IDW'(k);
            end
        end
    end

    // Last-grant pointer; reset value makes requester 0 the first winner.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)          last_q <= IDW'(NREQ - 1);
        else if (handshake) last_q <= grant_idx;
    end
`endif

    assign handshake = (state == IDLE) && grant_any;

    // One-hot accept, only in IDLE and forced low while reset is held.
    always_comb begin
        ready_vec = '0;
        if (handshake && !i_rst) ready_vec[grant_idx] = 1'b1;
    end

    assign o_req_ready = ready_vec;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: grant -> settle one cycle -> hold until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_any) state_nxt = ADD;
            ADD:     state_nxt = RESP;
            RESP:    if (i_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the winner's operands and index on the accept edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            id_q <= '0;
        end else if (handshake) begin
            a_q  <= i_req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_q  <= i_req_b[int'(grant_idx)*WIDTH +: WIDTH];
            id_q <= grant_idx;
        end
    end

    ripple_carry_adder_60bit #(.WIDTH(WIDTH)) u_adder (
        .a    (a_q),
        .b    (b_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Register the settled sum at the end of ADD; it then holds through RESP.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)              result_q <= '0;
        else if (state == ADD)  result_q <= {add_cout, add_sum};
    end

    assign o_rsp_valid  = (state == RESP);
    assign o_rsp_id     = id_q;
    assign o_rsp_result = result_q;
    assign o_busy       = (state != IDLE);
endmodule
